// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// fills the IF/ID pipeline register. Handles branch redirects, hazard
// stalls and illegal fetch addresses, which park the stage in HALT.
module fetch_stage #(
  parameter int unsigned IMEM_SIZE  = 1024,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  input  logic [31:0] instruction,
  output logic [63:0] imem_addr,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fault
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;
  logic [63:0] pc_next;
  logic [63:0] if_id_pc_next;
  logic [31:0] if_id_instr_next;
  logic        if_id_valid_next;
  logic        bad_pc;

  // Full 64-bit bound check so a wrapped or runaway PC is always caught.
  assign bad_pc = (pc[1:0] != 2'b00) || ((pc + 64'd3) >= 64'(IMEM_SIZE));

  assign imem_addr = pc;
  // HALT is only ever entered on an illegal fetch, so it doubles as the sticky fault flag.
  assign fault     = (state == HALT);

  // State, PC and IF/ID register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= '0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      if_id_pc    <= if_id_pc_next;
      if_id_instr <= if_id_instr_next;
      if_id_valid <= if_id_valid_next;
    end
  end

  // Next-state, next-PC and IF/ID selection; default is hold PC and load a bubble.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    if_id_pc_next    = '0;
    if_id_instr_next = '0;
    if_id_valid_next = 1'b0;
    case (state)
      RUN: begin
        if (bad_pc) begin
          state_next = HALT;
        end else if (stall) begin
          if_id_pc_next    = if_id_pc;
          if_id_instr_next = if_id_instr;
          if_id_valid_next = if_id_valid;
        end else if (br_taken) begin
          if (br_target[1:0] != 2'b00) begin
            state_next = HALT;
          end else begin
            pc_next = br_target;
            if (DELAY_SLOT) begin
              if_id_pc_next    = pc;
              if_id_instr_next = instruction;
              if_id_valid_next = 1'b1;
            end
          end
        end else begin
          pc_next          = pc + 64'd4;
          if_id_pc_next    = pc;
          if_id_instr_next = instruction;
          if_id_valid_next = 1'b1;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one instance with a delay slot, one without,
// sharing stimulus; each has its own ROM model returning X for illegal addresses.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;

  logic [31:0] instr1, instr0;
  logic [63:0] imem1, imem0;
  logic [63:0] pc1, pc0;
  logic [31:0] ir1, ir0;
  logic        v1, v0;
  logic        f1, f0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [63:0] a);
    if (a[1:0] == 2'b00 && a < 64'd1024) return 32'h9100_0000 + 32'(a >> 2);
    return 'x;
  endfunction

  assign instr1 = rom(imem1);
  assign instr0 = rom(imem0);

  fetch_stage #(.IMEM_SIZE(1024), .DELAY_SLOT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .instruction(instr1), .imem_addr(imem1),
    .if_id_pc(pc1), .if_id_instr(ir1), .if_id_valid(v1), .fault(f1)
  );

  fetch_stage #(.IMEM_SIZE(1024), .DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .instruction(instr0), .imem_addr(imem0),
    .if_id_pc(pc0), .if_id_instr(ir0), .if_id_valid(v0), .fault(f0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected values for both instances: shared PC and fault, per-instance IF/ID.
  task automatic check_all(input string tag, input logic [63:0] e_addr, input logic e_fault,
                           input logic [63:0] e_pc1, input logic [31:0] e_ir1, input logic e_v1,
                           input logic [63:0] e_pc0, input logic [31:0] e_ir0, input logic e_v0);
    check({tag, ".addr1"},  imem1,         e_addr);
    check({tag, ".addr0"},  imem0,         e_addr);
    check({tag, ".fault1"}, 64'(f1),       64'(e_fault));
    check({tag, ".fault0"}, 64'(f0),       64'(e_fault));
    check({tag, ".pc1"},    pc1,           e_pc1);
    check({tag, ".ir1"},    64'(ir1),      64'(e_ir1));
    check({tag, ".v1"},     64'(v1),       64'(e_v1));
    check({tag, ".pc0"},    pc0,           e_pc0);
    check({tag, ".ir0"},    64'(ir0),      64'(e_ir0));
    check({tag, ".v0"},     64'(v0),       64'(e_v0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    step();
    step();
    check_all("reset", 64'h0, 1'b0, 64'h0, 32'h0, 1'b0, 64'h0, 32'h0, 1'b0);

    // Straight-line run from address 0.
    reset = 1'b0;
    check_all("run0", 64'h0, 1'b0, 64'h0, 32'h0, 1'b0, 64'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_all("run", 64'(4 * i), 1'b0,
                64'(4 * (i - 1)), 32'h9100_0000 + 32'(i - 1), 1'b1,
                64'(4 * (i - 1)), 32'h9100_0000 + 32'(i - 1), 1'b1);
    end

    // Restart and branch from pc = 8 to 0x40.
    reset = 1'b1;
    step();
    check_all("rst2", 64'h0, 1'b0, 64'h0, 32'h0, 1'b0, 64'h0, 32'h0, 1'b0);
    reset = 1'b0;
    step();
    step();
    check_all("pre_br", 64'h8, 1'b0, 64'h4, 32'h9100_0001, 1'b1, 64'h4, 32'h9100_0001, 1'b1);
    br_taken = 1'b1; br_target = 64'h40;
    step();
    check_all("br_slot", 64'h40, 1'b0, 64'h8, 32'h9100_0002, 1'b1, 64'h0, 32'h0, 1'b0);
    br_taken = 1'b0;
    step();
    check_all("br_tgt", 64'h44, 1'b0, 64'h40, 32'h9100_0010, 1'b1, 64'h40, 32'h9100_0010, 1'b1);

    // Get to pc = 12, then stall for 3 cycles with a branch to 0x80 pending.
    br_taken = 1'b1; br_target = 64'hC;
    step();
    check_all("to12", 64'hC, 1'b0, 64'h44, 32'h9100_0011, 1'b1, 64'h0, 32'h0, 1'b0);
    stall = 1'b1; br_target = 64'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("stall", 64'hC, 1'b0, 64'h44, 32'h9100_0011, 1'b1, 64'h0, 32'h0, 1'b0);
    end
    stall = 1'b0;
    step();
    check_all("unstall_br", 64'h80, 1'b0, 64'hC, 32'h9100_0003, 1'b1, 64'h0, 32'h0, 1'b0);
    br_taken = 1'b0;
    step();
    check_all("stall_tgt", 64'h84, 1'b0, 64'h80, 32'h9100_0020, 1'b1, 64'h80, 32'h9100_0020, 1'b1);

    // Misaligned branch target parks both instances in HALT.
    br_taken = 1'b1; br_target = 64'h42;
    step();
    check_all("misalign", 64'h84, 1'b1, 64'h0, 32'h0, 1'b0, 64'h0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      br_taken  = (i % 2) == 0;
      stall     = (i % 3) == 1;
      br_target = 64'h100;
      step();
      check_all("halt_hold", 64'h84, 1'b1, 64'h0, 32'h0, 1'b0, 64'h0, 32'h0, 1'b0);
    end

    // Reset out of HALT, then a normal fetch from address 0.
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0;
    step();
    check_all("halt_rst", 64'h0, 1'b0, 64'h0, 32'h0, 1'b0, 64'h0, 32'h0, 1'b0);
    reset = 1'b0;
    step();
    check_all("recover", 64'h4, 1'b0, 64'h0, 32'h9100_0000, 1'b1, 64'h0, 32'h9100_0000, 1'b1);

    // Fall off the end of the ROM.
    br_taken = 1'b1; br_target = 64'h3FC;
    step();
    check_all("to_end", 64'h3FC, 1'b0, 64'h4, 32'h9100_0001, 1'b1, 64'h0, 32'h0, 1'b0);
    br_taken = 1'b0;
    step();
    check_all("last", 64'h400, 1'b0, 64'h3FC, 32'h9100_00FF, 1'b1, 64'h3FC, 32'h9100_00FF, 1'b1);
    step();
    check_all("off_end", 64'h400, 1'b1, 64'h0, 32'h0, 1'b0, 64'h0, 32'h0, 1'b0);
    step();
    check_all("off_end2", 64'h400, 1'b1, 64'h0, 32'h0, 1'b0, 64'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined LEGv8 CPU. It owns the program counter, drives the address of the combinational instruction ROM, and registers the returned word and its PC into the IF/ID pipeline register for the decode stage. It applies branch redirects from the branch-resolution logic and stalls from the hazard unit. It also detects illegal fetch addresses and parks the front end in a sticky fault state.

## Interface

Parameters:
- IMEM_SIZE, 1024: instruction ROM size in bytes; power of two, greater than 4.
- DELAY_SLOT, 1: 1 means the instruction fetched in the cycle a branch is accepted enters IF/ID (one delay slot). 0 means that instruction is squashed.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit hold request; freezes PC and IF/ID.
- br_taken  input  1  redirect request from branch resolution.
- br_target  input  64  byte address to redirect to.
- instruction  input  32  word returned combinationally by the instruction ROM for imem_addr.
- imem_addr  output  64  current PC; drives the ROM address.
- if_id_pc  output  64  PC of the instruction held in IF/ID.
- if_id_instr  output  32  instruction held in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
- fault  output  1  sticky illegal-fetch indicator.

## Operation

- State machine has two states, RUN and HALT. Reset enters RUN.
- Reset values:
  - pc = 0, so imem_addr = 0.
  - if_id_pc = 0, if_id_instr = 32'h0, if_id_valid = 0.
  - fault = 0.
- Reset has priority over every other input in any state.
- Priority in RUN, evaluated each posedge: bad_pc, then stall, then br_taken, then normal advance.
- bad_pc is defined as imem_addr[1:0] != 0 or imem_addr + 3 >= IMEM_SIZE, using 64-bit compare with no truncation.
  - Next state is HALT and fault becomes 1.
  - IF/ID loads a bubble (valid = 0, instr = 0, pc = 0). PC holds.
- stall = 1 (with the current PC legal):
  - PC, if_id_pc, if_id_instr and if_id_valid all hold.
  - br_taken in the same cycle is ignored. The producer re-asserts it on the next unstalled cycle.
- br_taken = 1 with stall = 0:
  - If br_target[1:0] != 0:
    - Next state is HALT and fault becomes 1. PC holds.
    - IF/ID loads a bubble.
  - Otherwise:
    - pc <= br_target.
    - With DELAY_SLOT = 1, IF/ID loads {imem_addr, instruction, valid = 1}.
    - With DELAY_SLOT = 0, IF/ID loads a bubble.
- Normal advance:
  - pc <= pc + 4, with 64-bit wrap. The bounds check catches the overflow case.
  - IF/ID loads {imem_addr, instruction, valid = 1}.
- HALT:
  - PC holds and IF/ID loads a bubble every cycle.
  - stall and br_taken are ignored. fault stays 1.
  - Only reset leaves HALT.
- The instruction input is never sampled when the PC is illegal, so X data from the ROM never reaches IF/ID.

## Timing

- imem_addr is a direct register output with no combinational path from any input.
- Fetch latency is one cycle: if imem_addr = A in cycle n, then if_id_pc = A and if_id_instr = mem[A/4] in cycle n+1.
- A redirect takes effect on the next cycle: br_taken accepted in cycle n gives imem_addr = br_target in cycle n+1.
  - With DELAY_SLOT = 1, the IF/ID sequence is: branch-cycle word, then target word.
  - With DELAY_SLOT = 0, the IF/ID sequence is: bubble, then target word.
- A stall held for k cycles extends both PC and IF/ID by exactly k cycles with no lost or duplicated instruction.
- fault rises on the posedge that accepts the illegal address. It remains 1 until the first posedge with reset = 1.
- Reset asserted mid-stream (including during HALT or stall) gives reset values on the next posedge. The first fetch from address 0 is captured one cycle after reset deasserts.

## Test plan

- **Reset then straight-line run.** Release reset and run 5 cycles with ROM words 0..4 = 0x91000000+i.
  - imem_addr steps 0, 4, 8, 12, 16.
  - IF/ID shows pc 0..12 with the matching words and valid = 1 from the second cycle.
- **Branch, both delay-slot settings.** At pc = 8, pulse br_taken with br_target = 0x40.
  - DELAY_SLOT = 1: IF/ID = {8, mem[2]}, then {0x40, mem[16]}.
  - DELAY_SLOT = 0: IF/ID = bubble, then {0x40, mem[16]}.
- **Stall with simultaneous branch.** At pc = 12, assert stall for 3 cycles with br_taken = 1 and br_target = 0x80 throughout.
  - PC stays 12 and IF/ID is frozen.
  - On the first unstalled cycle the branch is taken and imem_addr = 0x80 follows.
- **Misaligned target.** Pulse br_taken with br_target = 0x42.
  - fault = 1 next cycle, imem_addr is unchanged, and if_id_valid = 0.
  - This state persists across 10 cycles of further br_taken and stall activity.
- **Fall-off end.** Branch to IMEM_SIZE - 4 (0x3FC).
  - One valid fetch of 0x3FC occurs.
  - The next cycle the PC is 0x400, then fault = 1 and if_id_valid = 0.
- **Reset recovery.** Assert reset for 1 cycle while in HALT.
  - fault = 0, imem_addr = 0, if_id_valid = 0.
  - The next cycle fetches address 0 normally.
